fetch_stage: RTL and testbench



---
 rtl/riscv_pkg.sv | 14 +
 rtl/if_id_reg.sv | 66 ++++++
 rtl/fetch_stage.sv | 126 ++++++++++++
 tb/tb_fetch_stage.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V pipeline front end.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Fetch FSM: issue request, await response, hold buffered response under stall.
  typedef enum logic [1:0] {
    F_REQ  = 2'd0,
    F_WAIT = 2'd1,
    F_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush (bubble) > stall (hold) > load > bubble.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pcplus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pcplus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;

  // Next-state selection; a bubble keeps the PCs and only replaces the word.
  always_comb begin
    instr_d   = instr_q;
    pc_d      = pc_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (flush_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (stall_i) begin
      // hold everything
    end else if (load_i) begin
      instr_d   = instr_i;
      pc_d      = pc_i;
      pcplus4_d = pcplus4_i;
      valid_d   = 1'b1;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  // Register update with asynchronous reset to an empty bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= NOP_INSTR;
      pc_q      <= '0;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  assign instr_o   = instr_q;
  assign pc_o      = pc_q;
  assign pcplus4_o = pcplus4_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem request FSM, IF/ID register.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_D,
  input  logic        flush_D,
  input  logic        PCSrc_E,
  input  logic [31:0] PCTarget_E,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PCPlus4_D,
  output logic        valid_D
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         drop_q, drop_d;
  logic [31:0]  buf_q, buf_d;

  logic [31:0]  pc_plus4;
  logic [31:0]  target;
  logic         accept;
  logic         load;
  logic [31:0]  load_instr;

  assign pc_plus4  = pc_q + 32'd4;
  assign target    = PCTarget_E & 32'hFFFF_FFFC;
  assign imem_req  = (state_q == F_REQ) && !PCSrc_E && rst_n;
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_ready;

  // FSM next state, PC selection and IF/ID load request.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    buf_d      = buf_q;
    load       = 1'b0;
    load_instr = imem_rdata;
    unique case (state_q)
      F_REQ: begin
        if (PCSrc_E) begin
          pc_d = target;
        end else if (accept) begin
          state_d = F_WAIT;
        end
      end
      F_WAIT: begin
        if (imem_rvalid) begin
          // Response closes the transaction; it is only used if nothing
          // (drop, flush or a same-cycle redirect) marks it wrong-path.
          state_d = F_REQ;
          drop_d  = 1'b0;
          if (PCSrc_E) begin
            pc_d = target;
          end else if (!drop_q && !flush_D) begin
            if (stall_D) begin
              buf_d   = imem_rdata;
              state_d = F_HOLD;
            end else begin
              load = 1'b1;
              pc_d = pc_plus4;
            end
          end
        end else if (PCSrc_E) begin
          drop_d = 1'b1;
          pc_d   = target;
        end
      end
      F_HOLD: begin
        if (PCSrc_E) begin
          pc_d    = target;
          state_d = F_REQ;
        end else if (flush_D) begin
          state_d = F_REQ;
        end else if (!stall_D) begin
          load       = 1'b1;
          load_instr = buf_q;
          pc_d       = pc_plus4;
          state_d    = F_REQ;
        end
      end
      default: state_d = F_REQ;
    endcase
  end

  // FSM, PC and response buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= F_REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      buf_q   <= buf_d;
    end
  end

  if_id_reg u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush_D),
    .stall_i   (stall_D),
    .load_i    (load),
    .instr_i   (load_instr),
    .pc_i      (pc_q),
    .pcplus4_i (pc_plus4),
    .instr_o   (Instr_D),
    .pc_o      (PC_D),
    .pcplus4_o (PCPlus4_D),
    .valid_o   (valid_D)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_D, flush_D, PCSrc_E;
  logic [31:0] PCTarget_E;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] Instr_D, PC_D, PCPlus4_D;
  logic        valid_D;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall_D    (stall_D),
    .flush_D    (flush_D),
    .PCSrc_E    (PCSrc_E),
    .PCTarget_E (PCTarget_E),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .Instr_D    (Instr_D),
    .PC_D       (PC_D),
    .PCPlus4_D  (PCPlus4_D),
    .valid_D    (valid_D)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                          input logic [31:0] pc4, input logic v);
    chk({tag, ".Instr_D"},   Instr_D,   ins);
    chk({tag, ".PC_D"},      PC_D,      pc);
    chk({tag, ".PCPlus4_D"}, PCPlus4_D, pc4);
    chk({tag, ".valid_D"},   {31'd0, valid_D}, {31'd0, v});
  endtask

  task automatic chk_fetch(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, ".imem_req"},  {31'd0, imem_req}, {31'd0, req});
    chk({tag, ".imem_addr"}, imem_addr, addr);
  endtask

  initial begin
    rst_n = 1'b0; stall_D = 1'b0; flush_D = 1'b0; PCSrc_E = 1'b0;
    PCTarget_E = '0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    #12;
    chk_fetch("rst", 1'b0, 32'h0);
    chk_ifid("rst", 32'h13, 32'h0, 32'h0, 1'b0);
    tick();
    rst_n = 1'b1; #1;

    // Basic fetch: first request in the first cycle after release.
    chk_fetch("f0.req", 1'b1, 32'h0);
    tick();                                   // accepted -> WAIT
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; #1;
    chk_fetch("f0.wait", 1'b0, 32'h0);
    tick();
    imem_rvalid = 1'b0; #1;
    chk_ifid("f0.load", 32'h0050_0093, 32'h0, 32'h4, 1'b1);
    chk_fetch("f0.next", 1'b1, 32'h4);

    // Stall while the response arrives.
    tick();                                   // accepted at 4, bubble into IF/ID
    chk_ifid("st.bub", 32'h13, 32'h0, 32'h4, 1'b0);
    stall_D = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113; #1;
    tick();
    imem_rvalid = 1'b0; #1;
    chk_fetch("st.hold", 1'b0, 32'h4);
    chk_ifid("st.held", 32'h13, 32'h0, 32'h4, 1'b0);
    tick();
    chk_fetch("st.hold2", 1'b0, 32'h4);
    stall_D = 1'b0; #1;
    tick();
    chk_ifid("st.rel", 32'h00A0_0113, 32'h4, 32'h8, 1'b1);
    chk_fetch("st.next", 1'b1, 32'h8);

    // Redirect during WAIT: pending word dropped.
    tick();                                   // accepted at 8
    PCSrc_E = 1'b1; PCTarget_E = 32'h0000_0102; #1;
    tick();
    PCSrc_E = 1'b0; #1;
    chk_fetch("rd.wait", 1'b0, 32'h100);
    chk("rd.v1", {31'd0, valid_D}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    tick();
    imem_rvalid = 1'b0; #1;
    chk_ifid("rd.drop", 32'h13, 32'h4, 32'h8, 1'b0);
    chk_fetch("rd.req", 1'b1, 32'h100);
    tick();                                   // accepted at 0x100
    imem_rvalid = 1'b1; imem_rdata = 32'h0010_0193; #1;
    tick();
    imem_rvalid = 1'b0; #1;
    chk_ifid("rd.new", 32'h0010_0193, 32'h100, 32'h104, 1'b1);

    // Flush coinciding with the response.
    tick();                                   // accepted at 0x104
    flush_D = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111; #1;
    tick();
    flush_D = 1'b0; imem_rvalid = 1'b0; #1;
    chk_ifid("fl", 32'h13, 32'h100, 32'h104, 1'b0);
    chk_fetch("fl.pc", 1'b1, 32'h104);

    // Redirect in REQ to the top word, then wrap.
    PCSrc_E = 1'b1; PCTarget_E = 32'hFFFF_FFFF; #1;
    chk("wr.req_blk", {31'd0, imem_req}, 32'd0);
    tick();
    PCSrc_E = 1'b0; #1;
    chk_fetch("wr.top", 1'b1, 32'hFFFF_FFFC);
    tick();                                   // accepted
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0033; #1;
    tick();
    imem_rvalid = 1'b0; #1;
    chk_ifid("wr", 32'h0000_0033, 32'hFFFF_FFFC, 32'h0, 1'b1);
    chk_fetch("wr.next", 1'b1, 32'h0);

    // Reset during WAIT, late response afterwards is ignored.
    tick();                                   // accepted at 0 -> WAIT
    rst_n = 1'b0; #1;
    chk_fetch("rw.rst", 1'b0, 32'h0);
    chk_ifid("rw.rst", 32'h13, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1; imem_ready = 1'b0; #1;
    chk("rw.req", {31'd0, imem_req}, 32'd1);
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0BAD; #1;
    tick();
    imem_rvalid = 1'b0; #1;
    chk_ifid("rw.late", 32'h13, 32'h0, 32'h0, 1'b0);
    chk_fetch("rw.addr", 1'b1, 32'h0);
    tick();                                   // not ready: stays in REQ
    chk_fetch("rw.nrdy", 1'b1, 32'h0);
    imem_ready = 1'b1; #1;
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h0020_0213; #1;
    tick();
    imem_rvalid = 1'b0; #1;
    chk_ifid("rw.ok", 32'h0020_0213, 32'h0, 32'h4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
